// File: rtl/key_event_pkg.sv
// Shared constants for the multi-channel key event detector: event types,
// event-port filter modes, channel state encoding and counter sizing.
package key_event_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_REPEAT  = 2'd2;

  localparam int MODE_PRESS   = 0;
  localparam int MODE_RELEASE = 1;
  localparam int MODE_BOTH    = 2;

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } key_state_e;

  // The counter only has to reach max(a,b)-1 before it reloads.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key channel: RELEASED/PRESSED toggle driven by decoder strobes, an
// auto-repeat counter, and registered press/release/repeat pulses.
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CYCLES   = 100,
  parameter int REPEAT_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_valid_i,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);

  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] term;
  logic          first_q, first_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  assign term = first_q ? CW'(HOLD_CYCLES - 1) : CW'(REPEAT_CYCLES - 1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    if (state_q == ST_RELEASED) begin
      if (key_valid_i) begin
        state_d = ST_PRESSED;
        press_d = 1'b1;
        cnt_d   = '0;
        first_d = 1'b1;
      end
    end else begin
      // A release on the terminal-count cycle wins; the repeat is dropped.
      if (key_valid_i) begin
        state_d   = ST_RELEASED;
        release_d = 1'b1;
        cnt_d     = '0;
        first_d   = 1'b0;
      end else if (REPEAT_EN != 0) begin
        if (cnt_q == term) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
          first_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RELEASED;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign held_o    = (state_q == ST_PRESSED);
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_event_detector.sv
// Multi-channel key event detector: per-channel trackers feed one pending
// slot each, merged by a fixed-priority arbiter onto a valid/ready port.
module key_event_detector
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int MODE          = 2,
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CYCLES   = 100,
  parameter int REPEAT_CYCLES = 20,
  localparam int ID_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                evt_valid,
  output logic [ID_W-1:0]     evt_id,
  output logic [1:0]          evt_type,
  input  logic                evt_ready,
  output logic                evt_overflow
);

  // Event port handshake: the lowest-indexed pending slot is presented while
  // evt_valid=1; it is consumed on any cycle where evt_valid && evt_ready.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_event_chan #(
      .REPEAT_EN    (REPEAT_EN),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid_i(key_valid[g]),
      .held_o     (key_held[g]),
      .press_o    (press_pulse[g]),
      .release_o  (release_pulse[g]),
      .repeat_o   (repeat_pulse[g])
    );
  end

  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [NUM_KEYS-1:0] new_evt, xfer;
  logic [1:0]          type_q   [NUM_KEYS];
  logic [1:0]          type_d   [NUM_KEYS];
  logic [1:0]          new_type [NUM_KEYS];
  logic [ID_W-1:0]     sel;
  logic [1:0]          sel_type;
  logic                ovf_q, ovf_d;

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      new_evt[i]  = 1'b0;
      new_type[i] = EVT_PRESS;
      if (repeat_pulse[i]) begin
        new_evt[i]  = 1'b1;
        new_type[i] = EVT_REPEAT;
      end else if (release_pulse[i] && (MODE != MODE_PRESS)) begin
        new_evt[i]  = 1'b1;
        new_type[i] = EVT_RELEASE;
      end else if (press_pulse[i] && (MODE != MODE_RELEASE)) begin
        new_evt[i]  = 1'b1;
        new_type[i] = EVT_PRESS;
      end
    end
  end

  // Descending scan so the lowest pending index is the one left selected.
  always_comb begin
    sel      = '0;
    sel_type = EVT_PRESS;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel      = ID_W'(i);
        sel_type = type_q[i];
      end
    end
  end

  assign evt_valid = |pend_q;
  assign evt_id    = sel;
  assign evt_type  = sel_type;

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      xfer[i]   = evt_valid && evt_ready && (sel == ID_W'(i));
      type_d[i] = new_evt[i] ? new_type[i] : type_q[i];
    end
    pend_d = new_evt | (pend_q & ~xfer);
    ovf_d  = |(new_evt & pend_q & ~xfer);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) type_q[i] <= EVT_PRESS;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < NUM_KEYS; i++) type_q[i] <= type_d[i];
    end
  end

  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_key_event_detector.sv
// Directed bench: a MODE=2 instance for most scenarios plus a MODE=0
// instance for the press-only filter, both with HOLD=8 and REPEAT=4.
module tb_key_event_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_valid = '0;
  logic       evt_ready = 1'b1;
  logic [3:0] key_held, press_pulse, release_pulse, repeat_pulse;
  logic       evt_valid, evt_overflow;
  logic [1:0] evt_id, evt_type;

  logic [3:0] m_key_valid = '0;
  logic [3:0] m_key_held, m_press, m_release, m_repeat;
  logic       m_valid, m_overflow;
  logic [1:0] m_id, m_type;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_event_detector #(
    .NUM_KEYS(4), .MODE(2), .REPEAT_EN(1), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_held(key_held),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .evt_valid(evt_valid), .evt_id(evt_id),
    .evt_type(evt_type), .evt_ready(evt_ready), .evt_overflow(evt_overflow)
  );

  key_event_detector #(
    .NUM_KEYS(4), .MODE(0), .REPEAT_EN(1), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
  ) u_dut_m0 (
    .clk(clk), .rst_n(rst_n), .key_valid(m_key_valid), .key_held(m_key_held),
    .press_pulse(m_press), .release_pulse(m_release),
    .repeat_pulse(m_repeat), .evt_valid(m_valid), .evt_id(m_id),
    .evt_type(m_type), .evt_ready(1'b1), .evt_overflow(m_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] m);
    key_valid = m;
    tick();
    key_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    total++;
    if ({key_held, press_pulse, release_pulse, repeat_pulse} !== 16'h0) begin
      bad++; $display("FAIL reset_pulses got=%h exp=0", {key_held, press_pulse, release_pulse, repeat_pulse});
    end
    total++;
    if ({evt_valid, evt_id, evt_type, evt_overflow} !== 6'b0) begin
      bad++; $display("FAIL reset_evt got=%b exp=0", {evt_valid, evt_id, evt_type, evt_overflow});
    end
    total++;
    if ({m_key_held, m_valid, m_overflow} !== 6'b0) begin
      bad++; $display("FAIL reset_m0 got=%b exp=0", {m_key_held, m_valid, m_overflow});
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_press_release();
    strobe(4'b0010);
    total++;
    if (press_pulse !== 4'b0010 || key_held !== 4'b0010) begin
      bad++; $display("FAIL pr_press got=%b/%b exp=0010/0010", press_pulse, key_held);
    end
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL pr_evt_early got=%b exp=0", evt_valid);
    end
    tick();
    total++;
    if (press_pulse !== 4'b0 || evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_type !== 2'd0) begin
      bad++; $display("FAIL pr_press_evt got=p%b v%b id%0d t%0d exp=p0000 v1 id1 t0", press_pulse, evt_valid, evt_id, evt_type);
    end
    tick();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL pr_drain got=%b exp=0", evt_valid);
    end
    repeat (2) tick();
    strobe(4'b0010);
    total++;
    if (release_pulse !== 4'b0010 || key_held !== 4'b0000) begin
      bad++; $display("FAIL pr_release got=%b/%b exp=0010/0000", release_pulse, key_held);
    end
    tick();
    total++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_type !== 2'd1) begin
      bad++; $display("FAIL pr_release_evt got=v%b id%0d t%0d exp=v1 id1 t1", evt_valid, evt_id, evt_type);
    end
    repeat (2) tick();
  endtask

  task automatic test_repeat();
    logic exp_rep, exp_v;
    logic [1:0] exp_t;
    int nrep;
    nrep = 0;
    strobe(4'b0001);
    for (int k = 1; k <= 23; k++) begin
      tick();
      exp_rep = (k == 8) || (k == 12) || (k == 16) || (k == 20);
      exp_v   = (k == 1) || (k == 9) || (k == 13) || (k == 17) || (k == 21);
      exp_t   = (k == 1) ? 2'd0 : 2'd2;
      if (repeat_pulse[0]) nrep++;
      total++;
      if (repeat_pulse[0] !== exp_rep) begin
        bad++; $display("FAIL rep_pulse k=%0d got=%b exp=%b", k, repeat_pulse[0], exp_rep);
      end
      total++;
      if (evt_valid !== exp_v) begin
        bad++; $display("FAIL rep_valid k=%0d got=%b exp=%b", k, evt_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (evt_id !== 2'd0 || evt_type !== exp_t) begin
          bad++; $display("FAIL rep_evt k=%0d got=id%0d t%0d exp=id0 t%0d", k, evt_id, evt_type, exp_t);
        end
      end
    end
    total++;
    if (nrep != 4) begin
      bad++; $display("FAIL rep_count got=%0d exp=4", nrep);
    end
    // Counter is at its terminal value in this cycle; the release must win.
    strobe(4'b0001);
    total++;
    if (repeat_pulse[0] !== 1'b0 || release_pulse[0] !== 1'b1) begin
      bad++; $display("FAIL rep_rel_term got=rep%b rel%b exp=rep0 rel1", repeat_pulse[0], release_pulse[0]);
    end
    tick();
    total++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_type !== 2'd1) begin
      bad++; $display("FAIL rep_rel_evt got=v%b id%0d t%0d exp=v1 id0 t1", evt_valid, evt_id, evt_type);
    end
    tick();
    total++;
    if (evt_valid !== 1'b0 || repeat_pulse !== 4'b0) begin
      bad++; $display("FAIL rep_after got=v%b rep%b exp=v0 rep0000", evt_valid, repeat_pulse);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] ids [3];
    ids[0] = 2'd0; ids[1] = 2'd2; ids[2] = 2'd3;
    strobe(4'b1101);
    total++;
    if (press_pulse !== 4'b1101) begin
      bad++; $display("FAIL b2b_press got=%b exp=1101", press_pulse);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      total++;
      if (evt_valid !== 1'b1 || evt_id !== ids[j] || evt_type !== 2'd0 || evt_overflow !== 1'b0) begin
        bad++; $display("FAIL b2b_evt%0d got=v%b id%0d t%0d o%b exp=v1 id%0d t0 o0", j, evt_valid, evt_id, evt_type, evt_overflow, ids[j]);
      end
    end
    tick();
    total++;
    if (evt_valid !== 1'b0 || evt_overflow !== 1'b0) begin
      bad++; $display("FAIL b2b_drain got=v%b o%b exp=v0 o0", evt_valid, evt_overflow);
    end
    strobe(4'b1101);
    repeat (5) tick();
    total++;
    if (evt_valid !== 1'b0 || key_held !== 4'b0) begin
      bad++; $display("FAIL b2b_rel_drain got=v%b held%b exp=v0 held0000", evt_valid, key_held);
    end
  endtask

  task automatic test_overflow();
    int novf;
    novf = 0;
    evt_ready = 1'b0;
    strobe(4'b0100);
    repeat (4) begin
      tick();
      if (evt_overflow) novf++;
    end
    key_valid = 4'b0100;
    tick();
    key_valid = '0;
    repeat (5) begin
      tick();
      if (evt_overflow) novf++;
    end
    total++;
    if (novf != 1) begin
      bad++; $display("FAIL ovf_count got=%0d exp=1", novf);
    end
    total++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_type !== 2'd1) begin
      bad++; $display("FAIL ovf_evt got=v%b id%0d t%0d exp=v1 id2 t1", evt_valid, evt_id, evt_type);
    end
    evt_ready = 1'b1;
    tick();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_single got=%b exp=0", evt_valid);
    end
    tick();
  endtask

  task automatic test_mode_press_only();
    m_key_valid = 4'b1000;
    tick();
    m_key_valid = '0;
    tick();
    total++;
    if (m_valid !== 1'b1 || m_id !== 2'd3 || m_type !== 2'd0) begin
      bad++; $display("FAIL m0_press got=v%b id%0d t%0d exp=v1 id3 t0", m_valid, m_id, m_type);
    end
    tick();
    m_key_valid = 4'b1000;
    tick();
    m_key_valid = '0;
    total++;
    if (m_release !== 4'b1000) begin
      bad++; $display("FAIL m0_rel_pulse got=%b exp=1000", m_release);
    end
    repeat (2) begin
      tick();
      total++;
      if (m_valid !== 1'b0) begin
        bad++; $display("FAIL m0_no_release got=%b exp=0", m_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    strobe(4'b0010);
    tick();
    total++;
    if (evt_valid !== 1'b1 || key_held !== 4'b0010) begin
      bad++; $display("FAIL rm_pending got=v%b held%b exp=v1 held0010", evt_valid, key_held);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({key_held, press_pulse, release_pulse, repeat_pulse, evt_valid, evt_id, evt_type, evt_overflow} !== 22'h0) begin
      bad++; $display("FAIL rm_async got=%h exp=0", {key_held, press_pulse, release_pulse, repeat_pulse, evt_valid, evt_id, evt_type, evt_overflow});
    end
    evt_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (evt_valid !== 1'b0 || release_pulse !== 4'b0) begin
      bad++; $display("FAIL rm_no_release got=v%b rel%b exp=v0 rel0000", evt_valid, release_pulse);
    end
    strobe(4'b0010);
    total++;
    if (press_pulse !== 4'b0010 || key_held !== 4'b0010 || release_pulse !== 4'b0) begin
      bad++; $display("FAIL rm_repress got=p%b h%b r%b exp=p0010 h0010 r0000", press_pulse, key_held, release_pulse);
    end
    strobe(4'b0010);
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_press_release();
    test_repeat();
    test_back_to_back();
    test_overflow();
    test_mode_press_only();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event_detector.md
Name: key_event_detector

Overview:
- Multi-channel, parametrised successor to the single-key press/release toggle.
- Each channel receives one-cycle key_valid strobes from the keyboard decoder. Strobes alternate press, release, press, ...
- Per channel: tracks held state, emits registered press/release pulses and generates auto-repeat while held.
- Merges all channel events into one valid/ready event stream for downstream display/control logic.

Parameters:
- NUM_KEYS, 4, number of independent key channels (1..16).
- MODE, 2, event-port filter: 0 = press only, 1 = release only, 2 = press and release.
- REPEAT_EN, 1, 1 enables auto-repeat events while a key is held.
- HOLD_CYCLES, 100, cycles from press to the first repeat event (>=2).
- REPEAT_CYCLES, 20, cycles between subsequent repeat events (>=2).
- ID_W, derived, clog2(NUM_KEYS) with a minimum of 1; localparam, not overridable.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  NUM_KEYS  per-channel one-cycle strobe; each strobe toggles that channel's held state.
- key_held  output  NUM_KEYS  per-channel level; 1 while the key is pressed.
- press_pulse  output  NUM_KEYS  one-cycle pulse on a press; unaffected by MODE.
- release_pulse  output  NUM_KEYS  one-cycle pulse on a release; unaffected by MODE.
- repeat_pulse  output  NUM_KEYS  one-cycle pulse per repeat; always 0 when REPEAT_EN=0.
- evt_valid  output  1  an event is presented on evt_id/evt_type.
- evt_id  output  ID_W  channel index of the presented event.
- evt_type  output  2  0 = press, 1 = release, 2 = repeat.
- evt_ready  input  1  consumer accepts the event; transfer occurs when evt_valid && evt_ready.
- evt_overflow  output  1  one-cycle pulse when a pending event is overwritten.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All channels go to RELEASED.
  - Repeat counters and pending flags are cleared.
  - All outputs are 0.
  - Reset asserted mid-hold or mid-handshake discards all state; no release event is generated.
- Per-channel FSM, states RELEASED and PRESSED:
  - RELEASED with key_valid=1 -> PRESSED; press_pulse=1 in the next cycle.
  - PRESSED with key_valid=1 -> RELEASED; release_pulse=1 in the next cycle.
  - key_valid=0 holds the current state.
  - key_held mirrors the state register.
  - All pulse outputs are registered: exactly 1 cycle of latency from the key_valid cycle.
- Repeat (REPEAT_EN=1):
  - The counter clears on entering PRESSED and increments every cycle while PRESSED.
  - When the count reaches HOLD_CYCLES-1 (first repeat) or REPEAT_CYCLES-1 (later repeats), a repeat is generated and the counter reloads to 0.
  - The first repeat_pulse therefore appears HOLD_CYCLES cycles after press_pulse.
  - A release in the same cycle as a repeat terminal count suppresses the repeat; only the release is generated.
  - The counter width is sized for max(HOLD_CYCLES, REPEAT_CYCLES); it never wraps.
- Event capture:
  - Each channel has one pending slot holding a type.
  - Press/release events enter the slot only if MODE permits; repeat events always enter.
  - A new event on a channel whose slot is still pending and not transferred this cycle overwrites the slot and pulses evt_overflow.
  - If the slot transfers in the same cycle a new event arrives, the new event fills the slot with no overflow.
- Arbitration:
  - evt_valid = OR of all pending flags.
  - evt_id selects the lowest-indexed pending channel (fixed priority), and evt_type is that channel's type.
  - evt_id/evt_type are stable while evt_valid=1 && evt_ready=0, unless a higher-priority channel becomes pending (allowed).
  - A transfer clears only the selected slot; the next pending event is presented the following cycle.
  - Sustained throughput is one event per cycle.
- Simultaneous strobes on multiple channels are handled independently in the same cycle.

Decomposition:
- Package key_event_pkg:
  - Event-type constants EVT_PRESS=2'd0, EVT_RELEASE=2'd1, EVT_REPEAT=2'd2.
  - MODE constants MODE_PRESS=0, MODE_RELEASE=1, MODE_BOTH=2.
  - State encodings ST_RELEASED=0, ST_PRESSED=1.
- Sub-module key_event_chan, one per channel via generate:
  - Contains the FSM, repeat counter and pulse registers.
  - Outputs held, press, release and repeat.
- The top level holds the pending slots, MODE filter, priority arbiter and overflow logic.

Test Plan:
(All scenarios use NUM_KEYS=4, HOLD_CYCLES=8, REPEAT_CYCLES=4, MODE=2, evt_ready=1 unless noted.)
- Reset then key_valid[1] strobe at cycle 10 -> press_pulse[1] at 11, key_held[1]=1 from 11; evt_valid/evt_id=1/evt_type=0 at 12; second strobe at 30 -> release_pulse[1] at 31, key_held[1]=0.
- Hold key 0 for 20 cycles -> repeat_pulse[0] at press+8, +12, +16, +20; four type-2 events; the release strobe on a terminal-count cycle yields a release event only.
- Strobe keys 0, 2, 3 in the same cycle with evt_ready=1 -> press events delivered in order id 0, 2, 3 on consecutive cycles; no overflow.
- evt_ready=0, key 2 press then release 5 cycles later -> evt_overflow pulses once; after ready=1 the single event is id 2 type 1.
- MODE=0, press and release key 3 -> only the press event appears; release_pulse[3] still pulses.
- Assert rst_n=0 while key 1 is held with events pending -> all outputs 0 asynchronously; after release of reset the next key_valid[1] strobe is treated as a press.
